// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit with the HI/LO registers.
// Each operation retires one bit per cycle. Busy stalls dependent instructions
// while an operation runs.
// Build option: define MULTDIV_DIV_EN to include the restoring divider
// (DIV/DIVU). Without it, DIV/DIVU are no-ops and DivideByZero is tied low.
//
// state  | meaning
// IDLE   | waiting for Start; MTHI/MTLO are applied here
// RUN    | one shift-add / shift-subtract iteration per cycle, 32 iterations
// FINISH | sign correction, HI/LO write, Done pulse
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Operation,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic             DivideByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MULTDIV_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    iterCount;
  logic             signedOp;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;

  // Multiplier: {carry, upper half, multiplier bits still to be consumed}
  logic [2*WIDTH:0] prodAcc;
  logic [WIDTH-1:0] multiplicand;
  logic             prodNeg;
  logic [WIDTH:0]   prodSum;

`ifdef MULTDIV_DIV_EN
  logic [WIDTH:0]   remAcc;
  logic [WIDTH-1:0] quotAcc;
  logic [WIDTH-1:0] divisor;
  logic             quotNeg;
  logic             remNeg;
  logic             divZero;
  logic             divOp;
  logic             divZeroOut;
  logic [WIDTH+1:0] remShift;
  logic [WIDTH+1:0] remTrial;
`endif

  assign Busy = (state != IDLE);

  // Operand magnitudes: even Operation codes select the signed variants.
  always_comb begin
    signedOp = ~Operation[0];
    magA     = (signedOp && OperandA[WIDTH-1]) ? -OperandA : OperandA;
    magB     = (signedOp && OperandB[WIDTH-1]) ? -OperandB : OperandB;
  end

  // Shift-add step: add the multiplicand into the upper half when the LSB is set.
  always_comb begin
    prodSum = prodAcc[2*WIDTH:WIDTH] + (prodAcc[0] ? {1'b0, multiplicand} : '0);
  end

`ifdef MULTDIV_DIV_EN
  // Restoring divide step: shift in the next dividend bit and trial-subtract.
  // The extra top bit keeps the trial sign valid when the shifted remainder
  // reaches 2^WIDTH.
  always_comb begin
    remShift = {remAcc, quotAcc[WIDTH-1]};
    remTrial = remShift - {2'b00, divisor};
  end

  assign DivideByZero = divZeroOut;
`else
  assign DivideByZero = 1'b0;
`endif

  // Sequencer, datapath registers and architectural HI/LO.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      iterCount    <= '0;
      HI           <= '0;
      LO           <= '0;
      Done         <= 1'b0;
      prodAcc      <= '0;
      multiplicand <= '0;
      prodNeg      <= 1'b0;
`ifdef MULTDIV_DIV_EN
      remAcc       <= '0;
      quotAcc      <= '0;
      divisor      <= '0;
      quotNeg      <= 1'b0;
      remNeg       <= 1'b0;
      divZero      <= 1'b0;
      divOp        <= 1'b0;
      divZeroOut   <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
`ifdef MULTDIV_DIV_EN
      divZeroOut <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (Start) begin
            case (Operation)
              OP_MULT, OP_MULTU: begin
                multiplicand <= magA;
                prodAcc      <= {{(WIDTH+1){1'b0}}, magB};
                prodNeg      <= signedOp & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
                iterCount    <= '0;
`ifdef MULTDIV_DIV_EN
                divOp        <= 1'b0;
`endif
                state        <= RUN;
              end
`ifdef MULTDIV_DIV_EN
              OP_DIV, OP_DIVU: begin
                remAcc    <= '0;
                quotAcc   <= magA;
                divisor   <= magB;
                quotNeg   <= signedOp & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
                remNeg    <= signedOp & OperandA[WIDTH-1];
                divZero   <= (OperandB == '0);
                divOp     <= 1'b1;
                iterCount <= '0;
                state     <= RUN;
              end
`endif
              OP_MTHI: HI <= OperandA;
              OP_MTLO: LO <= OperandA;
              default: ;
            endcase
          end
        end

        RUN: begin
`ifdef MULTDIV_DIV_EN
          if (divOp) begin
            if (!remTrial[WIDTH+1]) begin
              remAcc  <= remTrial[WIDTH:0];
              quotAcc <= {quotAcc[WIDTH-2:0], 1'b1};
            end else begin
              remAcc  <= remShift[WIDTH:0];
              quotAcc <= {quotAcc[WIDTH-2:0], 1'b0};
            end
          end else begin
            prodAcc <= {1'b0, prodSum, prodAcc[WIDTH-1:1]};
          end
`else
          prodAcc <= {1'b0, prodSum, prodAcc[WIDTH-1:1]};
`endif
          iterCount <= iterCount + 1'b1;
          if (iterCount == CW'(WIDTH - 1)) begin
            state <= FINISH;
          end
        end

        FINISH: begin
`ifdef MULTDIV_DIV_EN
          if (divOp) begin
            // With a zero divisor the remainder is the dividend magnitude, so
            // restoring its sign hands back OperandA unchanged.
            HI         <= remNeg ? -remAcc[WIDTH-1:0] : remAcc[WIDTH-1:0];
            LO         <= divZero ? '1 : (quotNeg ? -quotAcc : quotAcc);
            divZeroOut <= divZero;
          end else begin
            {HI, LO} <= prodNeg ? -prodAcc[2*WIDTH-1:0] : prodAcc[2*WIDTH-1:0];
          end
`else
          {HI, LO} <= prodNeg ? -prodAcc[2*WIDTH-1:0] : prodAcc[2*WIDTH-1:0];
`endif
          Done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
